// File: rtl/dual_rd_fifo.sv
// dual_rd_fifo: single-write, dual-read FIFO with write-through to both read slots
// when fewer than two entries are stored, so an empty FIFO adds no latency.
module dual_rd_fifo #(
    parameter int Depth = 4,
    parameter int Width = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   wr_valid_i,
    input  logic [Width-1:0]       wr_data_i,
    output logic                   wr_rdy_o,
    output logic [1:0]             rd_valid_o,
    output logic [Width-1:0]       rd_data0_o,
    output logic [Width-1:0]       rd_data1_o,
    input  logic [1:0]             rd_rdy_i,
    output logic [$clog2(Depth):0] level_o
);
    localparam int PtrW = $clog2(Depth) + 1;
    localparam int AddrW = PtrW - 1;
    localparam logic [PtrW-1:0] DepthC = PtrW'(Depth);

    logic [PtrW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  w_count;
    logic [AddrW-1:0] w_rd_addr0, w_rd_addr1;
    logic             w_wr_acc, w_pop0, w_pop1;

    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign wr_rdy_o   = w_count < DepthC;
    assign w_wr_acc   = wr_valid_i & wr_rdy_o;
    assign w_rd_addr0 = r_rd_ptr[AddrW-1:0];
    assign w_rd_addr1 = w_rd_addr0 + AddrW'(1);
    // count==Depth already sets both valids, so wr_valid_i cannot leak in when full
    assign rd_valid_o[0] = (w_count != '0) | wr_valid_i;
    assign rd_valid_o[1] = (w_count >= PtrW'(2)) | ((w_count == PtrW'(1)) & wr_valid_i);
    assign rd_data0_o = (w_count == '0) ? wr_data_i : r_mem[w_rd_addr0];
    assign rd_data1_o = (w_count == PtrW'(1)) ? wr_data_i : r_mem[w_rd_addr1];
    assign w_pop0  = rd_valid_o[0] & rd_rdy_i[0];
    assign w_pop1  = w_pop0 & rd_valid_o[1] & rd_rdy_i[1];
    assign level_o = w_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_mem[r_wr_ptr[AddrW-1:0]] <= wr_data_i;
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            r_rd_ptr <= r_rd_ptr + PtrW'({1'b0, w_pop0} + {1'b0, w_pop1});
        end
    end

    // occupancy bound (pops never overtake writes) and slot-1-only accept is illegal
    assert property (@(posedge clk_i) disable iff (!rst_ni) w_count <= DepthC);
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(rd_valid_o[0] && rd_rdy_i == 2'b10));
endmodule

// File: doc/dual_rd_fifo.md
Name: dual_rd_fifo

Overview:
- Single-write, dual-read write-through FIFO feeding the dual-issue decode/issue stage.
- The producer pushes at most one entry per cycle. The consumer sees the two oldest entries and pops 0, 1 or 2 per cycle, in order.
- When the FIFO holds fewer than two entries, the incoming write data is forwarded combinationally to the read ports (write-through), so an empty FIFO adds zero latency.

Parameters:
- Depth, 4, number of storage entries; power of 2, >= 2.
- Width, 32, data width in bits.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous flush; empties the FIFO at the next edge.
- wr_valid_i  input  1  write request.
- wr_data_i  input  Width  write data.
- wr_rdy_o  output  1  FIFO can accept a write this cycle.
- rd_valid_o  output  2  bit0 = head entry valid; bit1 = second-oldest entry valid.
- rd_data0_o  output  Width  head entry data.
- rd_data1_o  output  Width  second-oldest entry data.
- rd_rdy_i  input  2  consumer accepts: bit0 = slot 0, bit1 = slot 1.
- level_o  output  clog2(Depth)+1  stored entry count (excludes bypassed write).

Behaviour:
- Pointers:
  - wr_ptr and rd_ptr are PtrW = clog2(Depth)+1 bits wide and wrap modulo 2^PtrW.
  - count = wr_ptr - rd_ptr, computed modulo 2^PtrW. count is always in 0..Depth.
  - Storage is addressed by ptr[PtrW-2:0]; addresses wrap naturally.
- Write side:
  - wr_rdy_o = (count < Depth). It depends only on registered state and has no combinational path from rd_rdy_i.
  - Write accepted (wr_acc) = wr_valid_i & wr_rdy_o.
  - On wr_acc, mem[wr_ptr] <= wr_data_i and wr_ptr += 1. This happens even when the entry is also popped via bypass in the same cycle.
- Read validity:
  - rd_valid_o[0] = (count >= 1) | wr_valid_i.
  - rd_valid_o[1] = (count >= 2) | ((count == 1) & wr_valid_i).
  - wr_valid_i never contributes to rd_valid_o when count == Depth; in that case wr_rdy_o = 0.
- Read data:
  - rd_data0_o = wr_data_i when count == 0, else mem[rd_ptr].
  - rd_data1_o = wr_data_i when count == 1, else mem[rd_ptr+1].
  - Read data is don't-care when the corresponding valid bit is 0.
- Pops (in order):
  - pop0 = rd_valid_o[0] & rd_rdy_i[0].
  - pop1 = pop0 & rd_valid_o[1] & rd_rdy_i[1].
  - rd_rdy_i[1] without rd_rdy_i[0] is illegal and pops nothing from slot 1 (asserted in simulation).
  - rd_ptr += pop0 + pop1, a 2-bit add.
  - The consumer may assert rd_rdy_i while valid is low; it has no effect.
- Bypass consistency: when a bypassed entry is popped, wr_ptr and rd_ptr advance together, so count stays consistent. Count never underflows.
- level_o = count, registered-state derived.
- Flush: flush_i = 1 sets wr_ptr = rd_ptr = 0 at the next edge, and all handshakes in that cycle are discarded. Outputs during the flush cycle are still driven combinationally, but the consumer must treat them as killed.
- Reset: pointers go to 0 and all memory entries to 0.
  - Post-reset outputs: wr_rdy_o = 1, rd_valid_o = {1'b0, wr_valid_i}, level_o = 0.
  - Reset asserted mid-transfer discards all contents immediately (asynchronous).
- Simulation-only checks:
  - Shadow level tracking wr_acc - (pop0 + pop1) stays within 0..Depth.
  - Total pops never exceed total writes.
  - No rd_rdy_i = 2'b10 while rd_valid_o[0] is high.

Test Plan:
- Bypass: reset; wr_valid=1, data=0xA0, rd_rdy=2'b01 in the same cycle -> rd_valid=2'b01, rd_data0=0xA0, pop0=1, level stays 0.
- Fill/full: Depth=4; write 0x1,0x2,0x3,0x4 with rd_rdy=0 -> level_o=4, wr_rdy_o=0. A fifth write (0x5) is not accepted and rd_valid=2'b11 with data0=0x1, data1=0x2.
- Dual pop with wrap: from full, rd_rdy=2'b11 for two cycles -> pops 0x1/0x2, then 0x3/0x4. Then write 0x6, 0x7 -> they land at wrapped addresses 0 and 1 and read back in order.
- Partial bypass: count=1 holding 0xB1; wr_valid with 0xB2 and rd_rdy=2'b11 -> data0=0xB1, data1=0xB2, both popped, level_o=0 next cycle.
- Simultaneous push+pop at full: level=4, rd_rdy=2'b01, wr_valid=1 -> write refused (wr_rdy=0 from state), level becomes 3 next cycle, write accepted the following cycle.
- Flush/reset: level=3, flush_i=1 with rd_rdy=2'b11 and wr_valid=1 -> next cycle level_o=0 and rd_valid=2'b00 (wr_valid low). Async rst_ni low mid-write -> outputs immediately at reset values.
